tc_clk_div_glitchfree: RTL and testbench

//  Runtime-programmable integer clock divider with a glitch-free ratio update and clock-enable, built on the tc_clk primitives.

---
 rtl/tc_clk_pkg.sv | 11 +
 rtl/tc_clk_mux2.sv | 12 +
 rtl/tc_clk_div_glitchfree.sv | 110 +++++++++++
 tb/tb_tc_clk_div_glitchfree.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tc_clk_pkg.sv
// Shared definitions for the tc_clk clock-generation primitives.
// Default ratio width, ratio type and the ratio value that selects bypass.
package tc_clk_pkg;

    localparam int unsigned TC_DIV_WIDTH = 8;

    typedef logic [TC_DIV_WIDTH-1:0] div_t;

    localparam int unsigned DIV_BYPASS = 1;

endpackage

// File: rtl/tc_clk_mux2.sv
// Two-input clock select. Stands in for the PDK clock-mux cell that carries keep/dont_touch.
// The caller changes sel_i only when both clock inputs are at the same level.
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic sel_i,
    output logic clk_o
);

    assign clk_o = sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/tc_clk_div_glitchfree.sv
// Runtime-programmable integer clock divider with bypass for ratio 1.
// Ratio changes and stop/start take effect only at period boundaries.
module tc_clk_div_glitchfree
    import tc_clk_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = TC_DIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 strobe_o,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV =
        (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] BYP_DIV    = DIV_WIDTH'(DIV_BYPASS);
    localparam logic                 RST_BYPASS = (RST_DIV == BYP_DIV);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_pending_div;
    logic                 r_clk_div;
    logic                 r_pending;
    logic                 r_bypass;
    logic                 r_run;

    logic [DIV_WIDTH-1:0] w_cnt_next;
    logic [DIV_WIDTH-1:0] w_half;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_apply;
    logic                 w_new_bypass;

    assign w_cnt_next   = r_cnt + DIV_WIDTH'(1);
    assign w_half       = r_div >> 1;
    assign w_last       = (r_cnt == (r_div - DIV_WIDTH'(1)));
    assign w_accept     = cfg_valid_i & ~r_pending;
    // A stopped or bypassed divider has no period end to wait for.
    assign w_apply      = r_pending & (r_bypass | ~r_run | w_last);
    assign w_new_bypass = (r_pending_div == BYP_DIV);

    always_ff @(posedge clk_i) begin
        // NOTE: every register here is state, so all updates are non-blocking;
        // later reads in this block still see the pre-edge values.
        if (rst_i) begin
            r_cnt         <= '0;
            r_div         <= RST_DIV;
            r_pending_div <= RST_DIV;
            r_clk_div     <= 1'b0;
            r_pending     <= 1'b0;
            r_bypass      <= RST_BYPASS;
            r_run         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending     <= 1'b1;
                r_pending_div <= (cfg_div_i == '0) ? BYP_DIV : cfg_div_i;
            end

            if (w_apply) begin
                r_pending <= 1'b0;
                r_div     <= r_pending_div;
                r_cnt     <= '0;
                if (w_new_bypass) begin
                    r_bypass  <= 1'b1;
                    r_run     <= 1'b0;
                    r_clk_div <= 1'b0;
                end else begin
                    // NOTE: leaving bypass on a rising clk_i edge with r_clk_div=1 keeps
                    // both mux inputs high across the select change, so no runt pulse.
                    r_bypass  <= 1'b0;
                    r_run     <= r_bypass | en_i;
                    r_clk_div <= r_bypass | en_i;
                end
            end else if (!r_bypass) begin
                if (r_run) begin
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_run     <= en_i;
                        r_clk_div <= en_i;
                    end else begin
                        r_cnt     <= w_cnt_next;
                        r_clk_div <= (w_cnt_next < w_half);
                    end
                end else if (en_i) begin
                    r_run     <= 1'b1;
                    r_cnt     <= '0;
                    r_clk_div <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready_o = ~r_pending;
    assign div_o       = r_div;
    assign strobe_o    = r_bypass ? (en_i & ~rst_i) : (r_run & (r_cnt == '0));

    tc_clk_mux2 u_clk_mux (
        .clk0_i (r_clk_div),
        .clk1_i (clk_i),
        .sel_i  (r_bypass),
        .clk_o  (clk_o)
    );

endmodule

// File: tb/tb_tc_clk_div_glitchfree.sv
// Scoreboard bench for tc_clk_div_glitchfree: expected per-cycle outputs are queued
// as stimulus is driven and compared after each clk_i rising edge.
module tb_tc_clk_div_glitchfree;
    import tc_clk_pkg::*;

    logic clk_i       = 1'b0;
    logic rst_i       = 1'b1;
    logic en_i        = 1'b1;
    logic cfg_valid_i = 1'b0;
    div_t cfg_div_i   = '0;
    logic cfg_ready_o;
    div_t div_o;
    logic strobe_o;
    logic clk_o;

    typedef struct {
        logic  hi;
        logic  lo;
        logic  stb;
        logic  rdy;
        div_t  div;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    tc_clk_div_glitchfree #(
        .DIV_WIDTH   (TC_DIV_WIDTH),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_div_i   (cfg_div_i),
        .div_o       (div_o),
        .strobe_o    (strobe_o),
        .clk_o       (clk_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk_i cycle: drive inputs at the falling edge and queue the outputs
    // expected just after the following rising edge.
    task automatic cyc(input int rst, input int en, input int valid, input int cdiv,
                       input int hi, input int lo, input int stb, input int rdy,
                       input int dv, input string tag);
        exp_t e;
        @(negedge clk_i);
        rst_i       = (rst != 0);
        en_i        = (en != 0);
        cfg_valid_i = (valid != 0);
        cfg_div_i   = div_t'(cdiv);
        e.hi  = (hi != 0);
        e.lo  = (lo != 0);
        e.stb = (stb != 0);
        e.rdy = (rdy != 0);
        e.div = div_t'(dv);
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk_i);
    endtask

    // n running cycles of ratio d; k0 is the counter phase produced by the first edge.
    task automatic run(input int d, input int k0, input int n, input int rdy,
                       input string tag, output int k_next);
        int k;
        int ph;
        k = k0;
        for (int i = 0; i < n; i++) begin
            ph = (k < d / 2) ? 1 : 0;
            cyc(0, 1, 0, 0, ph, ph, (k == 0) ? 1 : 0, rdy, d, tag);
            k = (k + 1) % d;
        end
        k_next = k;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".clk_hi"}, 32'(clk_o), 32'(e.hi));
                check({e.tag, ".strobe"}, 32'(strobe_o), 32'(e.stb));
                check({e.tag, ".ready"}, 32'(cfg_ready_o), 32'(e.rdy));
                check({e.tag, ".div"}, 32'(div_o), 32'(e.div));
                #6;
                check({e.tag, ".clk_lo"}, 32'(clk_o), 32'(e.lo));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;

        // Reset and default ratio 4.
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 4, "rst");
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 4, "rst");
        run(4, 0, 8, 1, "t1_d4", k);

        // Ratio 5 requested mid-period; the old period completes first.
        run(4, 0, 2, 1, "t2_pre", k);
        cyc(0, 1, 1, 5, 0, 0, 0, 0, 4, "t2_acc");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 4, "t2_old");
        run(5, 0, 10, 1, "t2_d5", k);

        // Into bypass, then back out to ratio 6.
        cyc(0, 1, 1, 1, 1, 1, 1, 0, 5, "t3_acc1");
        run(5, 1, 4, 0, "t3_wait", k);
        cyc(0, 1, 0, 0, 1, 0, 1, 1, 1, "t3_byp");
        cyc(0, 0, 0, 0, 1, 0, 0, 1, 1, "t3_byp_en0");
        cyc(0, 1, 0, 0, 1, 0, 1, 1, 1, "t3_byp");
        cyc(0, 1, 1, 6, 1, 0, 1, 0, 1, "t3_acc6");
        run(6, 0, 12, 1, "t3_d6", k);

        // Back to ratio 4, then stop at cnt=1 with en_i wiggling inside the period.
        cyc(0, 1, 1, 4, 1, 1, 1, 0, 6, "t4_acc");
        run(6, 1, 5, 0, "t4_wait", k);
        run(4, 0, 5, 1, "t4_d4", k);
        cyc(0, 0, 0, 0, 1, 1, 0, 1, 4, "t4_p1");
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 4, "t4_p2");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, "t4_p3");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, "t4_stop");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, "t4_idle");
        cyc(0, 1, 0, 0, 1, 1, 1, 1, 4, "t4_start");
        run(4, 1, 3, 1, "t4_run", k);

        // Ratio 0 maps to bypass; offers while pending are dropped.
        cyc(0, 1, 1, 0, 1, 1, 1, 0, 4, "t5_acc0");
        cyc(0, 1, 1, 7, 1, 1, 0, 0, 4, "t5_ign");
        cyc(0, 1, 1, 7, 0, 0, 0, 0, 4, "t5_ign");
        cyc(0, 1, 1, 7, 0, 0, 0, 0, 4, "t5_ign");
        cyc(0, 1, 1, 7, 1, 0, 1, 1, 1, "t5_byp");
        cyc(0, 1, 0, 0, 1, 0, 1, 1, 1, "t5_byp");

        // Ratio 3, then reset mid-period while ratio 8 is pending.
        cyc(0, 1, 1, 3, 1, 0, 1, 0, 1, "t6_acc3");
        run(3, 0, 4, 1, "t6_d3", k);
        cyc(0, 1, 1, 8, 0, 0, 0, 0, 3, "t6_acc8");
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 4, "t6_rst");
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 4, "t6_rst");
        run(4, 0, 8, 1, "t6_post", k);

        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        #20;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
